// File: rtl/instr_fetch_rom.sv
// Program store for the MCP core: loaded over a valid/ready byte stream, then
// serves registered instruction reads. Out-of-program addresses return NOP.
module instr_fetch_rom #(
  parameter int         DEPTH = 32,
  parameter int         AW    = 5,
  parameter logic [7:0] NOP   = 8'hC0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_load,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  input  logic          load_done,
  output logic          load_ready,
  input  logic [7:0]    address,
  output logic [7:0]    instruction,
  output logic          instr_valid,
  output logic [AW:0]   prog_len,
  output logic          load_err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t        state_reg;
  logic [AW:0]   wr_ptr_reg;
  logic [7:0]    store_reg [DEPTH];
  logic          full;
  logic          xfer;
  logic          in_prog;

  // DEPTH is a power of two, so the top pointer bit alone marks a full store.
  assign full       = wr_ptr_reg[AW];
  assign load_ready = (state_reg == LOAD) && !full;
  assign xfer       = (state_reg == LOAD) && !start_load && load_valid && !full;
  assign in_prog    = (address < 8'(prog_len));

  // Store words are reset so an aborted load leaves nothing behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        store_reg[i] <= NOP;
      end
    end else if (xfer) begin
      store_reg[wr_ptr_reg[AW-1:0]] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      wr_ptr_reg  <= '0;
      prog_len    <= '0;
      instruction <= NOP;
      instr_valid <= 1'b0;
      load_err    <= 1'b0;
    end else if (start_load) begin
      // start_load outranks load_done and any byte offered in the same cycle.
      state_reg   <= LOAD;
      wr_ptr_reg  <= '0;
      load_err    <= 1'b0;
      instr_valid <= 1'b0;
      instruction <= NOP;
    end else begin
      case (state_reg)
        IDLE: begin
          instruction <= NOP;
          instr_valid <= 1'b0;
        end
        LOAD: begin
          instruction <= NOP;
          instr_valid <= 1'b0;
          if (xfer) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
          end
          if (load_valid && full) begin
            load_err <= 1'b1;
          end
          if (load_done) begin
            state_reg <= RUN;
            prog_len  <= wr_ptr_reg + {{AW{1'b0}}, xfer};
          end
        end
        RUN: begin
          instruction <= in_prog ? store_reg[address[AW-1:0]] : NOP;
          instr_valid <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_rom.sv
// Randomised bench for instr_fetch_rom: a plain array/counter model predicts the
// load status and fetch results; fetch expectations go through a scoreboard queue.
module tb_instr_fetch_rom;

  localparam int         DEPTH = 32;
  localparam logic [7:0] NOP   = 8'hC0;
  localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_load = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_done = 1'b0;
  logic       load_ready;
  logic [7:0] address = 8'h00;
  logic [7:0] instruction;
  logic       instr_valid;
  logic [5:0] prog_len;
  logic       load_err;

  instr_fetch_rom dut (
    .clk         (clk),
    .reset       (reset),
    .start_load  (start_load),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_done   (load_done),
    .load_ready  (load_ready),
    .address     (address),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .prog_len    (prog_len),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] e;
  } fetch_t;

  fetch_t exp_q[$];
  int     n_checks = 0;
  int     n_fail = 0;

  // Behavioural model of the block.
  logic [7:0] m_mem [DEPTH];
  int         m_state, m_ptr, m_len;
  bit         m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    return (int'(a) < m_len) ? m_mem[a[4:0]] : NOP;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
    m_state = S_IDLE;
    m_ptr   = 0;
    m_len   = 0;
    m_err   = 1'b0;
  endtask

  task automatic check_status();
    chk("load_ready", 32'(load_ready), 32'(m_state == S_LOAD && m_ptr < DEPTH));
    chk("load_err", 32'(load_err), 32'(m_err));
    chk("prog_len", 32'(prog_len), 32'(m_len));
    if (m_state != S_RUN) begin
      chk("idle_instruction", 32'(instruction), 32'(NOP));
      chk("idle_instr_valid", 32'(instr_valid), 32'd0);
    end
  endtask

  // One clock of stimulus: check the status produced by the previous cycle,
  // then present new inputs and advance the model.
  task automatic step(input logic sl, input logic lv, input logic [7:0] d,
                      input logic dn, input logic fe, input logic [7:0] a);
    fetch_t f;
    @(negedge clk);
    check_status();
    start_load = sl;
    load_valid = lv;
    load_data  = d;
    load_done  = dn;
    if (fe) begin
      address = a;
      if (m_state == S_RUN && !sl) begin
        f.a = a;
        f.e = model_read(a);
        exp_q.push_back(f);
      end
    end
    if (sl) begin
      m_state = S_LOAD;
      m_ptr   = 0;
      m_err   = 1'b0;
    end else if (m_state == S_LOAD) begin
      if (lv) begin
        if (m_ptr < DEPTH) begin
          m_mem[m_ptr] = d;
          m_ptr++;
        end else begin
          m_err = 1'b1;
        end
      end
      if (dn) begin
        m_len   = m_ptr;
        m_state = S_RUN;
      end
    end
  endtask

  task automatic idle();              step(0, 0, 8'h00, 0, 0, 8'h00); endtask
  task automatic start();             step(1, 0, 8'h00, 0, 0, 8'h00); endtask
  task automatic send(input logic [7:0] b); step(0, 1, b, 0, 0, 8'h00); endtask
  task automatic done();              step(0, 0, 8'h00, 1, 0, 8'h00); endtask
  task automatic fetch(input logic [7:0] a); step(0, 0, 8'h00, 0, 1, a); endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    start_load = 1'b0;
    load_valid = 1'b0;
    load_done  = 1'b0;
    model_reset();
    @(negedge clk);
    check_status();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Scoreboard monitor: compares each registered fetch result.
  always @(posedge clk) begin
    fetch_t f;
    #1;
    if (instr_valid && exp_q.size() > 0) begin
      f = exp_q.pop_front();
      chk($sformatf("fetch[%0h]", f.a), 32'(instruction), 32'(f.e));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] b;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // load_done while IDLE is ignored; reset mid-stream discards the load.
    done();
    start();
    send(8'h11); send(8'h22); send(8'h33);
    apply_reset();
    idle();

    // Short program, in-range and out-of-range fetches.
    start();
    send(8'h14); send(8'h45); send(8'h9C);
    done();
    fetch(8'h01); fetch(8'h00); fetch(8'h02);
    fetch(8'h03); fetch(8'hFF);

    // Full store with load_valid held high, then an overflow byte.
    start();
    for (int i = 0; i < DEPTH; i++) send(8'(i * 7 + 3));
    send(8'hAA);
    done();
    fetch(8'd31); fetch(8'd0); fetch(8'd32); fetch(8'h9F);

    // Final byte together with load_done.
    start();
    send(8'h21); send(8'h52);
    step(0, 1, 8'h0E, 1, 0, 8'h00);
    fetch(8'h02); fetch(8'h03);

    // Reload from RUN; start_load beats a simultaneous load_done.
    start();
    step(1, 0, 8'h00, 1, 0, 8'h00);
    send(8'h3F);
    done();
    fetch(8'h00); fetch(8'h01);

    // Randomised programs with bubbles and random fetch addresses.
    for (int p = 0; p < 8; p++) begin
      start();
      n = $urandom_range(0, DEPTH);
      for (int i = 0; i < n; i++) begin
        while ($urandom_range(0, 3) == 0) idle();
        b = 8'($urandom);
        if (i == n - 1 && $urandom_range(0, 1) == 1) begin
          step(0, 1, b, 1, 0, 8'h00);
        end else begin
          send(b);
        end
      end
      if (m_state == S_LOAD) begin
        if (n == DEPTH && $urandom_range(0, 1) == 1) send(8'($urandom));
        done();
      end
      for (int k = 0; k < 16; k++) begin
        case ($urandom_range(0, 3))
          0:       fetch(8'($urandom));
          1:       fetch(8'(n));
          default: fetch(8'($urandom_range(0, DEPTH + 2)));
        endcase
      end
    end

    idle();
    idle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
